// File: rtl/pixel_oem_split.sv
// Odd/even memory splitter: buffers STI_DAC pixel writes and replays them as registered strobes into
// eight 32x8 band memories. Optional build macro OEM_CNT_CHECK_EN adds a write-count integrity check.
module pixel_oem_split #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_wr,
  input  logic [7:0] pixel_addr,
  input  logic [7:0] pixel_dataout,
  input  logic       pixel_finish,
  output logic [4:0] oem_addr,
  output logic [7:0] oem_dataout,
  output logic       odd1_wr,
  output logic       odd2_wr,
  output logic       odd3_wr,
  output logic       odd4_wr,
  output logic       even1_wr,
  output logic       even2_wr,
  output logic       even3_wr,
  output logic       even4_wr,
  output logic       oem_finish,
  output logic       oem_ovf,
  output logic       oem_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_empty, fifo_full, pop, push;
  logic [15:0]   head;
  logic [4:0]    addr_q;
  logic [7:0]    data_q;
  logic [2:0]    sel_q;
  logic [7:0]    strb_q, strb_d;
  logic          flag_q, finish_q, finish_d, ovf_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  // The writer may take a new entry whenever it is not in the setup cycle of the current one.
  assign pop        = !fifo_empty && (state_q != SETUP);
  assign push       = pixel_wr && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr_q];

  // NOTE: FIFO storage has no reset; the count register alone decides which entries are valid,
  // so the array maps onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {pixel_addr, pixel_dataout};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    strb_d  = '0;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = SETUP;
      SETUP: begin
        state_d = STROBE;
        strb_d  = 8'(8'b1 << sel_q);
      end
      STROBE:  state_d = fifo_empty ? IDLE : SETUP;
      default: state_d = IDLE;
    endcase
  end

  assign finish_d = finish_q | (flag_q && fifo_empty && (state_q == IDLE));

  // Strobe index: bits 0-3 are ODD1-4, bits 4-7 are EVEN1-4; checkerboard parity picks the bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      strb_q   <= '0;
      flag_q   <= 1'b0;
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb_d;
      flag_q   <= flag_q | pixel_finish;
      finish_q <= finish_d;
      ovf_q    <= ovf_q | (pixel_wr && !push);
      if (pop) begin
        addr_q <= head[13:9];
        data_q <= head[7:0];
        sel_q  <= {~(head[12] ^ head[8]), head[15:14]};
      end
    end
  end

`ifdef OEM_CNT_CHECK_EN
  logic [8:0] wr_cnt_q;
  logic       err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == STROBE) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (finish_d && !finish_q) err_q <= err_q | (wr_cnt_q != 9'd256) | ovf_q;
    end
  end

  assign oem_err = err_q;
`else
  assign oem_err = 1'b0;
`endif

  assign oem_addr    = addr_q;
  assign oem_dataout = data_q;
  assign {even4_wr, even3_wr, even2_wr, even1_wr, odd4_wr, odd3_wr, odd2_wr, odd1_wr} = strb_q;
  assign oem_finish  = finish_q;
  assign oem_ovf     = ovf_q;

endmodule
